// File: rtl/pipe_shifter_pkg.sv
// Shared shifter definitions: op encodings and level-split helpers.
package pipe_shifter_pkg;

  // Shift operation encodings, shared with the ALU and decoder.
  typedef enum logic [1:0] {
    ShSll = 2'b00,
    ShRor = 2'b01,
    ShSrl = 2'b10,
    ShSra = 2'b11
  } shiftop_e;

  // Levels owned by each stage (ceiling split).
  function automatic int unsigned levels_per_stage(int unsigned shamt_w, int unsigned stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

  // First level owned by stage s.
  function automatic int unsigned stage_first_level(int unsigned shamt_w, int unsigned stages,
                                                    int unsigned s);
    return s * levels_per_stage(shamt_w, stages);
  endfunction

  // Number of levels owned by stage s; trailing stages may own fewer (or none).
  function automatic int unsigned stage_level_count(int unsigned shamt_w, int unsigned stages,
                                                    int unsigned s);
    int unsigned first;
    int unsigned lps;
    first = stage_first_level(shamt_w, stages, s);
    lps   = levels_per_stage(shamt_w, stages);
    if (first >= shamt_w) begin
      return 0;
    end else if (shamt_w - first < lps) begin
      return shamt_w - first;
    end else begin
      return lps;
    end
  endfunction

endpackage

// File: rtl/shift_levels.sv
// Combinational slice of the barrel shifter: applies a contiguous range of levels.
module shift_levels
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_W     = 5,
  parameter int unsigned FIRST_LEVEL = 0,
  parameter int unsigned NUM_LEVELS  = 1
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SHAMT_W-1:0]    shamt,
  input  shiftop_e              op,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] d;
  logic [SHAMT_W-1:0]    sel;

  // Apply owned levels LSB first; level i moves the data by 2^i when shamt[i] is set.
  always_comb begin
    d   = data_in;
    sel = '0;
    for (int unsigned i = FIRST_LEVEL; i < FIRST_LEVEL + NUM_LEVELS; i++) begin
      sel = shamt >> i;
      if (sel[0]) begin
        unique case (op)
          ShSll: d = d << (1 << i);
          ShSrl: d = d >> (1 << i);
          ShSra: d = $unsigned($signed(d) >>> (1 << i));
          ShRor: d = (d >> (1 << i)) | (d << (DATA_WIDTH - (1 << i)));
        endcase
      end
    end
  end

  assign data_out = d;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake and in-order tagged results.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 5,
  localparam int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [SHAMT_W-1:0]    B,
  input  logic [1:0]            Shiftop,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [TAG_W-1:0]      out_tag
);

  // Whole pipe moves as one; a full output that is not taken freezes every stage.
  logic en;

  // Index s holds what feeds stage s (the input port for s = 0, stage s-1 otherwise).
  logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] src_data;
  logic [PIPE_STAGES-1:0][SHAMT_W-1:0]    src_shamt;
  logic [PIPE_STAGES-1:0][1:0]            src_op;
  logic [PIPE_STAGES-1:0][TAG_W-1:0]      src_tag;
  logic [PIPE_STAGES-1:0]                 src_valid;

  // Shifted data for stage s, and the registered outputs of stage s.
  logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] lvl_data;
  logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] stage_data;
  logic [PIPE_STAGES-1:0][TAG_W-1:0]      stage_tag;
  logic [PIPE_STAGES-1:0]                 stage_valid;

  assign en       = !stage_valid[PIPE_STAGES-1] || out_ready;
  assign in_ready = en;

  // in_valid doubles as the accept strobe since the stage only loads when en = in_ready.
  assign src_data[0]  = A;
  assign src_shamt[0] = B;
  assign src_op[0]    = Shiftop;
  assign src_tag[0]   = in_tag;
  assign src_valid[0] = in_valid;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int unsigned First = stage_first_level(SHAMT_W, PIPE_STAGES, s);
    localparam int unsigned Count = stage_level_count(SHAMT_W, PIPE_STAGES, s);

    logic [DATA_WIDTH-1:0] data_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  valid_q;

    shift_levels #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W),
      .FIRST_LEVEL(First),
      .NUM_LEVELS (Count)
    ) u_levels (
      .data_in (src_data[s]),
      .shamt   (src_shamt[s]),
      .op      (shiftop_e'(src_op[s])),
      .data_out(lvl_data[s])
    );

    // Stage data/tag/valid register; reset clears everything so in-flight ops vanish.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        tag_q   <= '0;
        valid_q <= 1'b0;
      end else if (en) begin
        data_q  <= lvl_data[s];
        tag_q   <= src_tag[s];
        valid_q <= src_valid[s];
      end
    end

    assign stage_data[s]  = data_q;
    assign stage_tag[s]   = tag_q;
    assign stage_valid[s] = valid_q;

    // Only stages feeding further levels need to carry the shift amount and op.
    if (s < PIPE_STAGES - 1) begin : g_fwd
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         op_q;

      // Shift amount and op travel alongside the data they apply to.
      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
          op_q    <= '0;
        end else if (en) begin
          shamt_q <= src_shamt[s];
          op_q    <= src_op[s];
        end
      end

      assign src_data[s+1]  = data_q;
      assign src_shamt[s+1] = shamt_q;
      assign src_op[s+1]    = op_q;
      assign src_tag[s+1]   = tag_q;
      assign src_valid[s+1] = valid_q;
    end
  end

  assign Result    = stage_data[PIPE_STAGES-1];
  assign out_tag   = stage_tag[PIPE_STAGES-1];
  assign out_valid = stage_valid[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed plus random bench for pipe_shifter with an in-order scoreboard.
module tb_pipe_shifter;

  localparam int unsigned DW = 32;
  localparam int unsigned PS = 2;
  localparam int unsigned TW = 5;
  localparam int unsigned SW = $clog2(DW);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] A;
  logic [SW-1:0] B;
  logic [1:0]    Shiftop;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Result;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  pipe_shifter #(
    .DATA_WIDTH (DW),
    .PIPE_STAGES(PS),
    .TAG_W      (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Shiftop  (Shiftop),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .out_tag  (out_tag)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference: whole-word shift/rotate, independent of the level split.
  function automatic logic [DW-1:0] ref_shift(logic [DW-1:0] a, logic [SW-1:0] b, logic [1:0] op);
    logic [2*DW-1:0] dbl;
    case (op)
      OP_SLL:  return a << b;
      OP_SRL:  return a >> b;
      OP_SRA:  return $unsigned($signed(a) >>> b);
      default: begin
        dbl = {a, a} >> b;
        return dbl[DW-1:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score the handshakes at negedge, then advance past posedge.
  task automatic step(input logic v, input logic [1:0] op, input logic [DW-1:0] a,
                      input logic [SW-1:0] b, input logic [TW-1:0] t, input logic ordy,
                      input logic [DW-1:0] exp);
    exp_t e;
    in_valid  = v;
    Shiftop   = op;
    A         = a;
    B         = b;
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_output", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("result", Result, e.data);
        chk("tag", out_tag, e.tag);
        pop_cyc.push_back(cyc);
      end
    end
    if (in_valid && in_ready) sb.push_back('{data: exp, tag: t});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, '0, '0, '0, ordy, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) idle(1'b1);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] hold_res;
    logic [TW-1:0] hold_tag;
    int            n0;
    logic [DW-1:0] ra;
    logic [SW-1:0] rb;
    logic [1:0]    rop;

    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Shiftop   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", Result, '0);
    chk("rst_out_tag", out_tag, '0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Latency: result shows up PS cycles after the handshake cycle
    step(1'b1, OP_SLL, 32'h0000_0001, 5'd31, 5'd7, 1'b1, 32'h8000_0000);
    for (int k = 1; k < int'(PS); k++) begin
      chk("lat_wait", out_valid, 1'b0);
      idle(1'b1);
    end
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_result", Result, 32'h8000_0000);
    chk("lat_tag", out_tag, 5'd7);
    drain();

    // Back-to-back, consecutive in-order results
    n0 = pop_cyc.size();
    step(1'b1, OP_SRL, 32'h8000_0000, 5'd4, 5'd1, 1'b1, 32'h0800_0000);
    step(1'b1, OP_SRA, 32'h8000_0000, 5'd31, 5'd2, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, OP_ROR, 32'h8000_0001, 5'd1, 5'd3, 1'b1, 32'hC000_0000);
    drain();
    chk("b2b_count", pop_cyc.size() - n0, 3);
    if (pop_cyc.size() - n0 == 3) begin
      chk("b2b_gap1", pop_cyc[n0+1] - pop_cyc[n0], 1);
      chk("b2b_gap2", pop_cyc[n0+2] - pop_cyc[n0+1], 1);
    end

    // Backpressure: 3 stalled cycles with an op offered that must not be taken
    step(1'b1, OP_SLL, 32'h0000_00F0, 5'd4, 5'd4, 1'b1, 32'h0000_0F00);
    step(1'b1, OP_SRL, 32'h0000_00F0, 5'd4, 5'd5, 1'b1, 32'h0000_000F);
    step(1'b1, OP_ROR, 32'h0000_00F1, 5'd4, 5'd6, 1'b1, 32'h1000_000F);
    chk("bp_pre_valid", out_valid, 1'b1);
    hold_res = Result;
    hold_tag = out_tag;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, OP_SLL, 32'hDEAD_BEEF, 5'd1, 5'd9, 1'b0, 32'hBD5B_7DDE);
      chk("bp_result_hold", Result, hold_res);
      chk("bp_tag_hold", out_tag, hold_tag);
      chk("bp_valid_hold", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    drain();

    // Zero shift amount passes A through for every op
    step(1'b1, OP_SLL, 32'hA5A5_A5A5, 5'd0, 5'd10, 1'b1, 32'hA5A5_A5A5);
    step(1'b1, OP_ROR, 32'hA5A5_A5A5, 5'd0, 5'd11, 1'b1, 32'hA5A5_A5A5);
    step(1'b1, OP_SRL, 32'hA5A5_A5A5, 5'd0, 5'd12, 1'b1, 32'hA5A5_A5A5);
    step(1'b1, OP_SRA, 32'hA5A5_A5A5, 5'd0, 5'd13, 1'b1, 32'hA5A5_A5A5);
    drain();

    // Reset with two ops in flight; they must never appear
    step(1'b1, OP_SLL, 32'h0000_0003, 5'd2, 5'd20, 1'b0, 32'h0000_000C);
    step(1'b1, OP_SLL, 32'h0000_0003, 5'd3, 5'd21, 1'b0, 32'h0000_0018);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("midrst_flushed", out_valid, 1'b0);
    end

    // Random ops with random valid and out_ready
    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = SW'($urandom_range(0, DW - 1));
      rop = 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, rop, ra, rb, TW'(i), $urandom_range(0, 3) != 0,
           ref_shift(ra, rb, rop));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
